// File: rtl/instr_fetch_aligner.sv
// instr_fetch_aligner
//   Halfword realignment buffer between instruction fetch and decode. Aligned
//   32-bit fetch words are split into halfwords in a 4-entry circular queue.
//   One complete instruction is presented per handshake: a zero-extended
//   16-bit compressed instruction, or a 32-bit instruction that may straddle
//   two fetch words. The PC of the head instruction is tracked.
//
// Ports
//   clk_i, rst_n_i      clock (rising edge), async active-low reset
//   fetch_word_i        aligned fetch word; [15:0] at PC, [31:16] at PC+2
//   fetch_valid_i       fetch word valid
//   fetch_ready_o       aligner accepts a word this cycle (registered state only)
//   flush_i, flush_pc_i redirect: drop buffered halfwords, restart at flush_pc_i
//   instr_o             head instruction ({16'b0, hw} when compressed)
//   instr_is_c_o        head is compressed; instr_o[15:0] feeds the expander
//   instr_pc_o          PC of the head instruction
//   instr_valid_o       a complete instruction is at the head
//   instr_ready_i       decode accepts the head this cycle
module instr_fetch_aligner #(
   parameter int unsigned           XLEN     = 64,
   parameter logic [XLEN-1:0]       RESET_PC = 64'h8000_0000
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [31:0]     fetch_word_i,
   input  logic            fetch_valid_i,
   output logic            fetch_ready_o,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc_i,
   output logic [31:0]     instr_o,
   output logic            instr_is_c_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            instr_valid_o,
   input  logic            instr_ready_i
);

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned HW_W   = 16;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_SKIP = 1'b1
   } state_e;

   logic [HW_W-1:0]  q_q [DEPTH];
   logic [HW_W-1:0]  q_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN-1:0]  head_pc_q, head_pc_d;
   state_e           state_q, state_d;

   logic [HW_W-1:0]  head_hw;
   logic [HW_W-1:0]  next_hw;
   logic             head_is_c;
   logic [CNT_W-1:0] need;
   logic             push;
   logic             consume;
   logic [PTR_W-1:0] wr_ptr;

   // Head decode: the low two bits of the first halfword select the length.
   always_comb begin
      head_hw       = q_q[rd_ptr_q];
      next_hw       = q_q[rd_ptr_q + PTR_W'(1)];
      head_is_c     = (head_hw[1:0] != 2'b11);
      need          = head_is_c ? CNT_W'(1) : CNT_W'(2);
      instr_valid_o = (state_q == ST_RUN) && (count_q >= need);
      instr_is_c_o  = head_is_c;
      instr_o       = head_is_c ? {16'h0000, head_hw} : {next_hw, head_hw};
      instr_pc_o    = head_pc_q;
      fetch_ready_o = (count_q <= CNT_W'(2));
      push          = fetch_valid_i && fetch_ready_o;
      consume       = instr_valid_o && instr_ready_i;
      // A push needs count <= 2, so the low count bits give the write offset.
      wr_ptr        = rd_ptr_q + count_q[PTR_W-1:0];
   end

   // Next-state: flush overrides any push/consume in the same cycle.
   always_comb begin
      q_d       = q_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      head_pc_d = head_pc_q;
      state_d   = state_q;

      if (flush_i) begin
         rd_ptr_d  = '0;
         count_d   = '0;
         head_pc_d = flush_pc_i & ~XLEN'(1);
         state_d   = flush_pc_i[1] ? ST_SKIP : ST_RUN;
      end else begin
         if (consume) begin
            rd_ptr_d  = rd_ptr_q + need[PTR_W-1:0];
            head_pc_d = head_pc_q + XLEN'({need, 1'b0});
         end
         if (push) begin
            if (state_q == ST_SKIP) begin
               // Odd-halfword target: the low halfword precedes the target PC.
               q_d[wr_ptr] = fetch_word_i[31:16];
               state_d     = ST_RUN;
            end else begin
               q_d[wr_ptr]              = fetch_word_i[15:0];
               q_d[wr_ptr + PTR_W'(1)]  = fetch_word_i[31:16];
            end
         end
         count_d = count_q
                 + (push    ? ((state_q == ST_SKIP) ? CNT_W'(1) : CNT_W'(2)) : CNT_W'(0))
                 - (consume ? need : CNT_W'(0));
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_q[i] <= '0;
         end
         rd_ptr_q  <= '0;
         count_q   <= '0;
         head_pc_q <= RESET_PC;
         state_q   <= ST_RUN;
      end else begin
         q_q       <= q_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         head_pc_q <= head_pc_d;
         state_q   <= state_d;
      end
   end

endmodule
